dcache_refill_writer: RTL and testbench



---
 rtl/dcache_refill_writer.sv | 83 ++++++++
 tb/tb_dcache_refill_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_writer.sv
// dcache_refill_writer: line-fill engine that invalidates the victim, fetches eight beats
// from memory into the bank RAMs, then rewrites tag/valid and returns the assembled line.
module dcache_refill_writer #(
   parameter int INDEX_SIZE = 7,
   parameter int TAG_SIZE   = 20,
   parameter int BANK_NUM   = 8,
   parameter int TAGV_SIZE  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     miss_req,
   input  logic [31:0]              miss_addr,
   output logic                     miss_ready,
   output logic                     mem_rd_req,
   output logic [31:0]              mem_rd_addr,
   input  logic                     mem_rd_ack,
   input  logic                     mem_rd_valid,
   input  logic [31:0]              mem_rd_data,
   input  logic                     mem_rd_last,
   output logic [BANK_NUM-1:0]      bank_write_en,
   output logic [INDEX_SIZE-1:0]    write_addr,
   output logic [31:0]              write_data,
   output logic                     tagv_write_en,
   output logic [TAGV_SIZE-1:0]     tagv_write_data,
   output logic                     refill_done,
   output logic                     refill_error,
   output logic [BANK_NUM*32-1:0]   refill_data
);
   localparam int CNT_W = $clog2(BANK_NUM);
   typedef enum logic [2:0] {IDLE, INVAL, REQ, RECV, TAGV, DONE} state_t;
   state_t state, state_nx;
   logic [31:0] addr_q;
   logic [CNT_W-1:0] beat_cnt;
   logic err;
   logic [BANK_NUM*32-1:0] line;
   logic beat, fin;
   assign beat = state == RECV && mem_rd_valid;
   assign fin = mem_rd_last || beat_cnt == CNT_W'(BANK_NUM - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         addr_q   <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
         line     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && miss_req) begin
            addr_q   <= miss_addr;
            beat_cnt <= '0;
            err      <= 1'b0;
         end
         if (beat) begin
            line[32*int'(beat_cnt) +: 32] <= mem_rd_data;
            beat_cnt <= beat_cnt + 1'b1;
            if (mem_rd_last && beat_cnt != CNT_W'(BANK_NUM - 1)) err <= 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = miss_req ? INVAL : IDLE;
         INVAL: state_nx = REQ;
         REQ:   state_nx = mem_rd_ack ? RECV : REQ;
         RECV:  state_nx = (mem_rd_valid && fin) ? TAGV : RECV;
         TAGV:  state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   // bank write path is combinational so the RAM captures each beat on its own edge
   assign bank_write_en   = beat ? BANK_NUM'(1) << beat_cnt : '0;
   assign write_data      = beat ? mem_rd_data : '0;
   assign write_addr      = addr_q[INDEX_SIZE+4:5];
   assign miss_ready      = state == IDLE;
   assign mem_rd_req      = state == REQ;
   assign mem_rd_addr     = addr_q & ~32'h1f;
   assign tagv_write_en   = state == INVAL || state == TAGV;
   assign tagv_write_data = state == TAGV ? TAGV_SIZE'({~err, addr_q[31:32-TAG_SIZE]}) : '0;
   assign refill_done     = state == DONE;
   assign refill_error    = state == DONE && err;
   assign refill_data     = line;
endmodule

// File: tb/tb_dcache_refill_writer.sv
// tb_dcache_refill_writer: randomized refills against a queue-based scoreboard of the
// expected RAM writes and completion, each tagged with the cycle it must appear in.
module tb_dcache_refill_writer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic miss_req = 1'b0;
   logic [31:0] miss_addr = '0;
   logic miss_ready, mem_rd_req, mem_rd_ack = 1'b0;
   logic [31:0] mem_rd_addr;
   logic mem_rd_valid = 1'b0, mem_rd_last = 1'b0;
   logic [31:0] mem_rd_data = '0;
   logic [7:0] bank_write_en;
   logic [6:0] write_addr;
   logic [31:0] write_data;
   logic tagv_write_en;
   logic [31:0] tagv_write_data;
   logic refill_done, refill_error;
   logic [255:0] refill_data;

   dcache_refill_writer dut (
      .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
      .miss_ready(miss_ready), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .mem_rd_last(mem_rd_last), .bank_write_en(bank_write_en), .write_addr(write_addr),
      .write_data(write_data), .tagv_write_en(tagv_write_en), .tagv_write_data(tagv_write_data),
      .refill_done(refill_done), .refill_error(refill_error), .refill_data(refill_data));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cyc;
      logic [7:0] en;
      logic [6:0] addr;
      logic [31:0] data;
      logic err;
      logic [255:0] line;
      logic [255:0] mask;
   } evt_t;
   evt_t q[$];
   int n_chk = 0, n_pass = 0;

   task automatic check(input bit ok, input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic check_reset_outputs(input string nm);
      logic [319:0] a, e;
      a = 320'({miss_ready, mem_rd_req, mem_rd_addr, bank_write_en, write_addr, write_data,
                tagv_write_en, tagv_write_data, refill_done, refill_error});
      e = 320'(1) << 115;
      check(a == e, {nm, "_ctl"}, a, e);
      check(refill_data == '0, {nm, "_line"}, 320'(refill_data), '0);
   endtask

   task automatic push(input int kind, input int c, input logic [7:0] en, input logic [6:0] addr,
                       input logic [31:0] data, input logic err, input logic [255:0] line,
                       input logic [255:0] mask);
      evt_t e;
      e.kind = kind; e.cyc = c; e.en = en; e.addr = addr; e.data = data;
      e.err = err; e.line = line; e.mask = mask;
      q.push_back(e);
   endtask

   task automatic expect_evt(input int kind);
      evt_t e;
      logic [319:0] a, x;
      if (q.size() == 0) begin
         check(1'b0, "unexpected_output", 320'(kind), '1);
         return;
      end
      e = q.pop_front();
      if (kind == 0) begin
         a = {16'(0), 32'(cyc), 8'(write_addr), tagv_write_data};
         x = {16'(e.kind), 32'(e.cyc), 8'(e.addr), e.data};
         check(a == x, "tagv_write", a, x);
      end else if (kind == 1) begin
         a = {16'(1), 32'(cyc), bank_write_en, 8'(write_addr), write_data};
         x = {16'(e.kind), 32'(e.cyc), e.en, 8'(e.addr), e.data};
         check(a == x, "bank_write", a, x);
      end else begin
         a = {16'(2), 32'(cyc), 8'(refill_error), 8'(refill_done), refill_data & e.mask};
         x = {16'(e.kind), 32'(e.cyc), 8'(e.err), 8'(1), e.line};
         check(a == x, "refill_done", a, x);
      end
   endtask

   // monitor: samples 2ns after the falling edge, when driven inputs have settled
   initial begin
      bit done_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            if (done_prev) check(miss_ready, "ready_after_done", 320'(miss_ready), 320'(1));
            done_prev = refill_done;
            if (bank_write_en != 0 && tagv_write_en)
               check(1'b0, "single_write", 320'({bank_write_en, tagv_write_en}), 320'(0));
            if (bank_write_en != 0 && $countones(bank_write_en) != 1)
               check(1'b0, "onehot_en", 320'(bank_write_en), 320'(0));
            if (tagv_write_en) expect_evt(0);
            if (bank_write_en != 0) expect_evt(1);
            if (refill_done || refill_error) expect_evt(2);
         end else done_prev = 1'b0;
      end
   end

   // last_at: beat index carrying mem_rd_last (8 = none); abort_at: beat index at which reset hits (-1 = none)
   task automatic run_miss(input logic [31:0] addr, input int d, input int g, input int last_at,
                           input int extra, input int abort_at, input bit hold,
                           input logic [31:0] addr2, input bit pat, input bit junk);
      logic [31:0] bd[8];
      logic [255:0] ln, mk;
      int t, c, b, nn, nb;
      bit er;
      for (int k = 0; k < 8; k++) bd[k] = pat ? 32'(k + 1) * 32'h11111111 : $urandom;
      t = 0;
      while (!miss_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!miss_ready) begin
         check(1'b0, "ready_timeout", 320'(miss_ready), 320'(1));
         return;
      end
      nn = last_at < 8 ? last_at + 1 : 8;
      er = nn < 8;
      nb = abort_at >= 0 ? abort_at : nn;
      ln = '0;
      mk = '0;
      for (int k = 0; k < nn; k++) begin
         ln[32*k +: 32] = bd[k];
         mk[32*k +: 32] = '1;
      end
      c = cyc;
      b = c + 3 + d;
      push(0, c + 1, 8'h0, addr[11:5], 32'h0, 1'b0, '0, '0);
      for (int k = 0; k < nb; k++)
         push(1, b + k * (g + 1), 8'(1) << k, addr[11:5], bd[k], 1'b0, '0, '0);
      if (abort_at < 0) begin
         push(0, b + (nn - 1) * (g + 1) + 1, 8'h0, addr[11:5], {11'b0, ~er, addr[31:12]}, 1'b0, '0, '0);
         push(2, b + (nn - 1) * (g + 1) + 2, 8'h0, addr[11:5], 32'h0, er, ln, mk);
      end
      miss_req = 1'b1;
      miss_addr = addr;
      @(negedge clk);
      if (hold) miss_addr = addr2;
      else begin
         miss_req = 1'b0;
         miss_addr = $urandom;
      end
      t = 0;
      while (!mem_rd_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      check(mem_rd_req && mem_rd_addr == {addr[31:5], 5'b0}, "mem_rd_addr",
            320'({mem_rd_req, mem_rd_addr}), 320'({1'b1, addr[31:5], 5'b0}));
      for (int i = 0; i < d; i++) begin
         mem_rd_valid = junk;
         mem_rd_data = $urandom;
         mem_rd_last = junk && $urandom_range(1, 0) == 1;
         @(negedge clk);
      end
      mem_rd_valid = 1'b0;
      mem_rd_last = 1'b0;
      mem_rd_ack = 1'b1;
      @(negedge clk);
      mem_rd_ack = 1'b0;
      for (int k = 0; k < nn + extra; k++) begin
         if (k == abort_at) begin
            reset = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_last = 1'b0;
            #1 check_reset_outputs("reset_midline");
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         mem_rd_valid = 1'b1;
         mem_rd_data = k < nn ? bd[k] : $urandom;
         mem_rd_last = k < nn ? k == last_at : $urandom_range(1, 0) == 1;
         @(negedge clk);
         if (k < nn - 1) begin
            mem_rd_valid = 1'b0;
            mem_rd_last = 1'b0;
            repeat (g) @(negedge clk);
         end
      end
      mem_rd_valid = 1'b0;
      mem_rd_last = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      @(negedge clk);
      run_miss(32'h0000_1A40, 0, 0, 8, 0, -1, 1'b0, 0, 1'b1, 1'b0);
      run_miss(32'h0000_1A40, 5, 2, 8, 0, -1, 1'b0, 0, 1'b1, 1'b0);
      run_miss(32'hDEAD_BEE0, 1, 0, 3, 0, -1, 1'b0, 0, 1'b0, 1'b0);
      run_miss(32'h1234_5678, 2, 1, 8, 0, -1, 1'b1, 32'hCAFE_0F00, 1'b0, 1'b1);
      run_miss(32'hCAFE_0F00, 0, 0, 8, 0, -1, 1'b0, 0, 1'b0, 1'b0);
      run_miss(32'h8000_0020, 1, 1, 8, 0, 5, 1'b0, 0, 1'b0, 1'b0);
      run_miss(32'h0F0F_0FE0, 0, 0, 8, 2, -1, 1'b0, 0, 1'b0, 1'b0);
      run_miss(32'h0000_0000, 0, 0, 7, 2, -1, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++)
         run_miss($urandom, $urandom_range(4, 0), $urandom_range(2, 0),
                  $urandom_range(3, 0) == 0 ? $urandom_range(7, 0) : 8,
                  $urandom_range(2, 0), -1, 1'b0, 0, 1'b0, $urandom_range(1, 0) == 1);
      repeat (20) @(negedge clk);
      check(q.size() == 0, "queue_drained", 320'(q.size()), 320'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
